bennett_phase_monitor: RTL

BENNETT_PHASE_MONITOR -- requirements
Module: bennett_phase_monitor

---
 rtl/bennett_pkg.sv | 21 ++
 rtl/bennett_therm_decode.sv | 40 ++++
 rtl/bennett_phase_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bennett_pkg.sv
// -----------------------------------------------------------------------------
// bennett_pkg
// Shared types and constants for the Bennett clock phase monitor.
//   bennett_state_e : monitor FSM states (IDLE, UP, DOWN, ERR)
//   CYCLE_CNT_W     : width of the completed-ramp counter
//   CYCLE_CNT_MAX   : saturation value of the completed-ramp counter
// No ports (package).
// -----------------------------------------------------------------------------
package bennett_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        ERR  = 2'd3
    } bennett_state_e;

    localparam int CYCLE_CNT_W = 16;
    localparam logic [CYCLE_CNT_W-1:0] CYCLE_CNT_MAX = '1;

endpackage

// File: rtl/bennett_therm_decode.sv
// -----------------------------------------------------------------------------
// bennett_therm_decode
// Combinational decoder for the positive phase rails of a Bennett clock.
// A legal word is a thermometer code filled from the LSB; level is the number
// of asserted rails and valid flags whether the word is a thermometer code.
// Ports:
//   clkp_i  [WIDTH-1:0] in  : positive phase rails
//   level_o [LW-1:0]    out : population count of clkp_i
//   valid_o             out : 1 when clkp_i is a thermometer code
// -----------------------------------------------------------------------------
module bennett_therm_decode #(
    parameter int WIDTH = 11,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] clkp_i,
    output logic [LW-1:0]    level_o,
    output logic             valid_o
);

    // gap[i] marks a set rail sitting above a clear one, which breaks the
    // thermometer property. The top bit has nothing above it.
    logic [WIDTH-1:0] gap;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gap
            assign gap[gi] = clkp_i[gi+1] & ~clkp_i[gi];
        end
    endgenerate
    assign gap[WIDTH-1] = 1'b0;

    assign valid_o = ~|gap;

    always_comb begin
        level_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level_o = level_o + LW'(clkp_i[i]);
        end
    end

endmodule

// File: rtl/bennett_phase_monitor.sv
// -----------------------------------------------------------------------------
// bennett_phase_monitor
// Watches the phase rails of a Bennett clock generator, tracks the ramp
// 0 -> WIDTH -> 0, counts completed ramps and flags protocol violations.
// All outputs are registered (one cycle after the sampling edge).
// Build option: define BENNETT_MON_COUNT_EN to implement the 16-bit
// saturating cycle counter; otherwise cycle_count is tied to zero.
// Ports:
//   ext_clk      in  : clock, rising edge
//   reset        in  : synchronous active-high reset
//   clkp [W]     in  : positive phase rails (thermometer code)
//   clkn [W]     in  : negative phase rails (nominally ~clkp)
//   level [LW]   out : last valid decoded level
//   dir_up       out : 0 only while ramping down
//   cycle_done   out : pulse when a full ramp returns to level 0
//   cycle_count  out : saturating count of completed ramps
//   err_comp     out : pulse, clkn was not the complement of clkp
//   err_code     out : pulse, clkp was not a thermometer code
//   err_step     out : pulse, illegal level transition
//   err_sticky   out : OR of all error pulses since reset
// -----------------------------------------------------------------------------
module bennett_phase_monitor
    import bennett_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic                   ext_clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       clkp,
    input  logic [WIDTH-1:0]       clkn,
    output logic [LW-1:0]          level,
    output logic                   dir_up,
    output logic                   cycle_done,
    output logic [CYCLE_CNT_W-1:0] cycle_count,
    output logic                   err_comp,
    output logic                   err_code,
    output logic                   err_step,
    output logic                   err_sticky
);

    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_TOP = LW'(WIDTH);

    logic [LW-1:0]  dec_level;
    logic           dec_valid;
    logic           comp_bad;
    logic           code_bad;

    bennett_state_e state_q,      state_d;
    logic [LW-1:0]  level_q,      level_d;
    logic           dir_up_q,     dir_up_d;
    logic           done_q,       done_d;
    logic           err_comp_q,   err_comp_d;
    logic           err_code_q,   err_code_d;
    logic           err_step_q,   err_step_d;
    logic           sticky_q,     sticky_d;

    bennett_therm_decode #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_decode (
        .clkp_i  (clkp),
        .level_o (dec_level),
        .valid_o (dec_valid)
    );

    assign comp_bad = (clkn != ~clkp);
    assign code_bad = ~dec_valid;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        done_d     = 1'b0;
        err_comp_d = comp_bad;
        err_code_d = code_bad;
        err_step_d = 1'b0;

        if (comp_bad || code_bad) begin
            // Rail faults override the ramp checker; the sample is not
            // trusted, so the level keeps its last good value.
            state_d = ERR;
        end else begin
            level_d = dec_level;
            case (state_q)
                IDLE: begin
                    if (dec_level == '0) begin
                        state_d = IDLE;
                    end else if (dec_level == LVL_ONE) begin
                        state_d = UP;
                    end else begin
                        err_step_d = 1'b1;
                        state_d    = ERR;
                    end
                end
                UP: begin
                    // level_q < WIDTH here, so the +1 cannot wrap.
                    if (dec_level == level_q + LVL_ONE) begin
                        state_d = (dec_level == LVL_TOP) ? DOWN : UP;
                    end else if (dec_level == level_q) begin
                        state_d = UP;
                    end else begin
                        err_step_d = 1'b1;
                        state_d    = ERR;
                    end
                end
                DOWN: begin
                    // level_q >= 1 here; a hold at the top is the turnaround.
                    if (dec_level == level_q - LVL_ONE) begin
                        if (dec_level == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DOWN;
                        end
                    end else if (dec_level == level_q) begin
                        state_d = DOWN;
                    end else begin
                        err_step_d = 1'b1;
                        state_d    = ERR;
                    end
                end
                ERR: begin
                    if (dec_level == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = ERR;
            endcase
        end

        sticky_d = sticky_q | err_comp_d | err_code_d | err_step_d;
        dir_up_d = (state_d != DOWN);
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            level_q    <= '0;
            dir_up_q   <= 1'b1;
            done_q     <= 1'b0;
            err_comp_q <= 1'b0;
            err_code_q <= 1'b0;
            err_step_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            dir_up_q   <= dir_up_d;
            done_q     <= done_d;
            err_comp_q <= err_comp_d;
            err_code_q <= err_code_d;
            err_step_q <= err_step_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef BENNETT_MON_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cycle_count_q;

    // Advances on the same edge that registers the cycle_done pulse.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (done_d && (cycle_count_q != CYCLE_CNT_MAX)) begin
            cycle_count_q <= cycle_count_q + CYCLE_CNT_W'(1);
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

    assign level      = level_q;
    assign dir_up     = dir_up_q;
    assign cycle_done = done_q;
    assign err_comp   = err_comp_q;
    assign err_code   = err_code_q;
    assign err_step   = err_step_q;
    assign err_sticky = sticky_q;

endmodule
